add_pipe: RTL and testbench

Parametrised, pipelined adder/subtractor that succeeds the fixed 8-bit ripple-carry adder in the arithmetic lab. The WIDTH-bit carry chain is cut into STAGES equal slices, one slice per clock, with the slice carry registered between stages. Operands and results are skewed and de-skewed so that one operation per cycle is accepted and retired. A valid/ready handshake on both sides lets the block sit between a register-file read port and a result write-back path with full backpressure.

---
 rtl/add_pipe_if.sv | 28 ++
 rtl/add_pipe.sv | 117 +++++++++++
 tb/tb_add_pipe.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// Master drives operands and out_ready; slave (the adder) drives results and in_ready.
interface add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES slices of SW bits,
// one slice per clock, with a single global advance shared by every stage.
module add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  add_pipe_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("add_pipe: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic             w_adv;
  logic             w_out_valid;
  logic             w_c_eff;
  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff      = bus.sub ? ~bus.b : bus.b;
  assign w_c_eff      = bus.sub | bus.cin;
  assign w_adv        = !w_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Stage gi consumes the lowest remaining operand slice and appends its sum slice
  // above the results already computed, so register widths shrink/grow per stage.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int IW = WIDTH - gi * SW;

      logic                  w_v_in;
      logic                  w_c_in;
      logic [IW-1:0]         w_a_in;
      logic [IW-1:0]         w_b_in;
      logic [SW:0]           w_sum;
      logic [(gi+1)*SW-1:0]  w_s_next;
      logic                  r_valid;
      logic [(gi+1)*SW-1:0]  r_s;

      if (gi == 0) begin : g_src
        assign w_v_in   = bus.in_valid;
        assign w_a_in   = bus.a;
        assign w_b_in   = w_b_eff;
        assign w_c_in   = w_c_eff;
        assign w_s_next = w_sum[SW-1:0];
      end else begin : g_src
        assign w_v_in   = g_stage[gi-1].r_valid;
        assign w_a_in   = g_stage[gi-1].g_keep.r_a;
        assign w_b_in   = g_stage[gi-1].g_keep.r_b;
        assign w_c_in   = g_stage[gi-1].g_keep.r_carry;
        assign w_s_next = {w_sum[SW-1:0], g_stage[gi-1].r_s};
      end

      assign w_sum = {1'b0, w_a_in[SW-1:0]} + {1'b0, w_b_in[SW-1:0]} + {{SW{1'b0}}, w_c_in};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_s     <= '0;
        end else if (w_adv) begin
          r_valid <= w_v_in;
          if (w_v_in) begin
            r_s <= w_s_next;
          end
        end
      end

      if (gi < STAGES - 1) begin : g_keep
        logic               r_carry;
        logic [IW-SW-1:0]   r_a;
        logic [IW-SW-1:0]   r_b;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
          end else if (w_adv && w_v_in) begin
            r_carry <= w_sum[SW];
            r_a     <= w_a_in[IW-1:SW];
            r_b     <= w_b_in[IW-1:SW];
          end
        end
      end else begin : g_tail
        logic r_co;
        logic r_ovf;
        logic r_zero;
        logic w_c_msb;

        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
        assign w_c_msb = w_a_in[SW-1] ^ w_b_in[SW-1] ^ w_sum[SW-1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_co   <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
          end else if (w_adv && w_v_in) begin
            r_co   <= w_sum[SW];
            r_ovf  <= w_c_msb ^ w_sum[SW];
            r_zero <= ~|w_s_next;
          end
        end
      end
    end
  endgenerate

  assign w_out_valid   = g_stage[STAGES-1].r_valid;
  assign bus.out_valid = w_out_valid;
  assign bus.s         = g_stage[STAGES-1].r_s;
  assign bus.co        = g_stage[STAGES-1].g_tail.r_co;
  assign bus.ovf       = g_stage[STAGES-1].g_tail.r_ovf;
  assign bus.zero      = g_stage[STAGES-1].g_tail.r_zero;
endmodule

// File: tb/tb_add_pipe.sv
// Directed/table-driven bench for add_pipe: main (32,4) instance plus
// (32,1), (32,32) and (8,2) instances for the parameter sweep.
module tb_add_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  add_pipe_if #(.WIDTH(32)) if_main ();
  add_pipe_if #(.WIDTH(32)) if_s1 ();
  add_pipe_if #(.WIDTH(32)) if_s32 ();
  add_pipe_if #(.WIDTH(8))  if_w8 ();

  add_pipe #(.WIDTH(32), .STAGES(4))  u_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
  add_pipe #(.WIDTH(32), .STAGES(1))  u_s1   (.clk(clk), .rst_n(rst_n), .bus(if_s1));
  add_pipe #(.WIDTH(32), .STAGES(32)) u_s32  (.clk(clk), .rst_n(rst_n), .bus(if_s32));
  add_pipe #(.WIDTH(8),  .STAGES(2))  u_w8   (.clk(clk), .rst_n(rst_n), .bus(if_w8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: signed overflow via the operand/result sign rule.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [31:0] bb;
    logic [32:0] t;
    res_t        r;
    bb     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.s    = t[31:0];
    r.co   = t[32];
    r.ovf  = (a[31] == bb[31]) && (r.s[31] != a[31]);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  task automatic apply_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub, input logic [31:0] es,
                           input logic eco, input logic eovf, input logic ezero);
    int          lat;
    logic [31:0] held;
    if_main.a         = a;
    if_main.b         = b;
    if_main.cin       = cin;
    if_main.sub       = sub;
    if_main.in_valid  = 1'b1;
    if_main.out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 64'(if_main.in_ready), 64'd1);
    @(negedge clk);
    if_main.in_valid = 1'b0;
    lat = 1;
    while (!if_main.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " s"}, 64'(if_main.s), 64'(es));
    chk({tag, " co/ovf/zero"}, 64'({if_main.co, if_main.ovf, if_main.zero}), 64'({eco, eovf, ezero}));
    $display("%s a=0x%08h b=0x%08h cin=%0d sub=%0d -> s=0x%08h co=%0d ovf=%0d zero=%0d lat=%0d",
             tag, a, b, cin, sub, if_main.s, if_main.co, if_main.ovf, if_main.zero, lat);
    held = if_main.s;
    @(negedge clk);
    chk({tag, " bubble out_valid"}, 64'(if_main.out_valid), 64'd0);
    chk({tag, " bubble s hold"}, 64'(if_main.s), 64'(held));
  endtask

  task automatic stream(input string tag, input int n, input int stall_len);
    res_t        q[$];
    logic [31:0] va[16];
    logic [31:0] vb[16];
    logic        vc[16];
    logic        vs[16];
    int          sent;
    int          got;
    int          stall_left;
    int          extra;
    bit          stalled;
    logic [31:0] held;
    for (int i = 0; i < n; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; stall_left = 0; stalled = 0; held = '0;
    for (int c = 0; c < 200 && got < n; c++) begin
      if (stall_len > 0 && !stalled && if_main.out_valid) begin
        stall_left = stall_len;
        stalled    = 1'b1;
      end
      if_main.out_ready = (stall_left == 0);
      if (sent < n) begin
        if_main.in_valid = 1'b1;
        if_main.a   = va[sent];
        if_main.b   = vb[sent];
        if_main.cin = vc[sent];
        if_main.sub = vs[sent];
      end else begin
        if_main.in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        chk($sformatf("%s stall in_ready c%0d", tag, c), 64'(if_main.in_ready), 64'd0);
        chk($sformatf("%s stall out_valid c%0d", tag, c), 64'(if_main.out_valid), 64'd1);
        if (stall_left == stall_len) held = if_main.s;
        else chk($sformatf("%s stall s hold c%0d", tag, c), 64'(if_main.s), 64'(held));
        stall_left--;
      end
      if (if_main.out_valid && if_main.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s extra result: got s=0x%08h, expected no result", tag, if_main.s);
        end else begin
          chk($sformatf("%s result %0d", tag, got),
              64'({if_main.s, if_main.co, if_main.ovf, if_main.zero}), 64'(q[0]));
          if (stall_len == 0)
            chk($sformatf("%s timing %0d", tag, got), 64'(c), 64'(got + 4));
          $display("%s result %0d s=0x%08h co=%0d ovf=%0d zero=%0d cycle=%0d",
                   tag, got, if_main.s, if_main.co, if_main.ovf, if_main.zero, c);
          void'(q.pop_front());
        end
        got++;
      end
      if (if_main.in_valid && if_main.in_ready) begin
        q.push_back(model(va[sent], vb[sent], vc[sent], vs[sent]));
        sent++;
      end
      @(negedge clk);
    end
    if_main.in_valid  = 1'b0;
    if_main.out_ready = 1'b1;
    chk({tag, " results received"}, 64'(got), 64'(n));
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_main.out_valid) extra++;
      @(negedge clk);
    end
    chk({tag, " no duplicate after drain"}, 64'(extra), 64'd0);
  endtask

  initial begin : main_seq
    int stale;
    int lat1, lat32, lat8;
    checks = 0;
    failures = 0;
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'h12345678, 32'h12345678, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1;
    if_main.in_valid = 1'b0; if_main.out_ready = 1'b0;
    if_main.a = '0; if_main.b = '0; if_main.cin = 1'b0; if_main.sub = 1'b0;
    if_s1.in_valid = 1'b0;  if_s1.out_ready = 1'b1;
    if_s1.a = '0; if_s1.b = '0; if_s1.cin = 1'b0; if_s1.sub = 1'b0;
    if_s32.in_valid = 1'b0; if_s32.out_ready = 1'b1;
    if_s32.a = '0; if_s32.b = '0; if_s32.cin = 1'b0; if_s32.sub = 1'b0;
    if_w8.in_valid = 1'b0;  if_w8.out_ready = 1'b1;
    if_w8.a = '0; if_w8.b = '0; if_w8.cin = 1'b0; if_w8.sub = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("reset out_valid", 64'(if_main.out_valid), 64'd0);
    chk("reset s", 64'(if_main.s), 64'd0);
    chk("reset co/ovf/zero", 64'({if_main.co, if_main.ovf, if_main.zero}), 64'd0);
    chk("reset in_ready", 64'(if_main.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      apply_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                tbl[i].s, tbl[i].co, tbl[i].ovf, tbl[i].zero);
    end

    stream("stream", 16, 0);
    stream("backpressure", 8, 3);

    // Reset with one result presented and three beats still in flight.
    if_main.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_main.in_valid = 1'b1;
      if_main.a   = (i == 0) ? 32'hFFFFFFFF : $urandom;
      if_main.b   = (i == 0) ? 32'h00000002 : $urandom;
      if_main.cin = 1'b0;
      if_main.sub = 1'b0;
      @(negedge clk);
    end
    if_main.in_valid = 1'b0;
    chk("pre-reset s", 64'({if_main.out_valid, if_main.s, if_main.co}), {31'd0, 1'b1, 32'h1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 64'(if_main.out_valid), 64'd0);
    chk("midreset s", 64'(if_main.s), 64'd0);
    chk("midreset co/ovf/zero", 64'({if_main.co, if_main.ovf, if_main.zero}), 64'd0);
    chk("midreset in_ready", 64'(if_main.in_ready), 64'd1);
    $display("midreset s=0x%08h out_valid=%0d", if_main.s, if_main.out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (if_main.out_valid) stale++;
      @(negedge clk);
    end
    chk("post-reset stale results", 64'(stale), 64'd0);
    apply_one("post-reset", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0);

    // Parameter sweep: all three instances fed on the same edge.
    if_s1.a = 32'h00FF00FF;  if_s1.b = 32'h00010001;  if_s1.cin = 1'b1;  if_s1.sub = 1'b0;
    if_s32.a = 32'h00FF00FF; if_s32.b = 32'h00010001; if_s32.cin = 1'b1; if_s32.sub = 1'b0;
    if_w8.a = 8'hFF;         if_w8.b = 8'h01;         if_w8.cin = 1'b1;  if_w8.sub = 1'b0;
    if_s1.out_ready = 1'b0; if_s32.out_ready = 1'b0; if_w8.out_ready = 1'b0;
    if_s1.in_valid = 1'b1;  if_s32.in_valid = 1'b1;  if_w8.in_valid = 1'b1;
    @(negedge clk);
    if_s1.in_valid = 1'b0;  if_s32.in_valid = 1'b0;  if_w8.in_valid = 1'b0;
    lat1 = 0; lat32 = 0; lat8 = 0;
    for (int e = 1; e <= 40; e++) begin
      if (lat1 == 0 && if_s1.out_valid) lat1 = e;
      if (lat32 == 0 && if_s32.out_valid) lat32 = e;
      if (lat8 == 0 && if_w8.out_valid) lat8 = e;
      @(negedge clk);
    end
    chk("sweep 32x1 latency", 64'(lat1), 64'd1);
    chk("sweep 32x1 s", 64'(if_s1.s), 64'h01000101);
    chk("sweep 32x1 co/ovf/zero", 64'({if_s1.co, if_s1.ovf, if_s1.zero}), 64'd0);
    chk("sweep 32x32 latency", 64'(lat32), 64'd32);
    chk("sweep 32x32 s", 64'(if_s32.s), 64'h01000101);
    chk("sweep 32x32 co/ovf/zero", 64'({if_s32.co, if_s32.ovf, if_s32.zero}), 64'd0);
    chk("sweep 8x2 latency", 64'(lat8), 64'd2);
    chk("sweep 8x2 s", 64'(if_w8.s), 64'h01);
    chk("sweep 8x2 co/ovf/zero", 64'({if_w8.co, if_w8.ovf, if_w8.zero}), 64'b100);
    $display("sweep lat 32x1=%0d 32x32=%0d 8x2=%0d s=0x%08h 0x%08h 0x%02h",
             lat1, lat32, lat8, if_s1.s, if_s32.s, if_w8.s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
